// File: rtl/gpc_fetch_ctrl.sv
// gpc_fetch_ctrl: instruction-fetch sequencer for the GPC.
// Owns the architectural PC and issues one fetch at a time, then holds the
// fetched word until the core commits it. Stops on ebreak or a fetch fault.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   mem_req_valid/ready/addr    fetch request to instruction memory
//   mem_rsp_valid/data          fetch response from instruction memory
//   inst, inst_valid/ready      instruction presented to / committed by core
//   next_pc, ebreak             commit-time info from the core
//   pc                          address of current or outstanding instruction
//   halted, fetch_err           sticky terminal status flags
module gpc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] next_pc,
  input  logic        ebreak,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fetch_err
);

  localparam int unsigned CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CntLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {StReq, StWait, StHold, StHalt, StErr} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    cnt_d         = cnt_q;
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    unique case (state_q)
      StReq: begin
        // Responses arriving here are stale (e.g. issued before a reset).
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A response in the final timeout cycle still wins.
        if (mem_rsp_valid) begin
          inst_d  = mem_rsp_data;
          state_d = StHold;
        end else if ((TIMEOUT != 0) && (cnt_q == CntW'(CntLast))) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          // ebreak outranks a misaligned next_pc; pc stays on the last instruction.
          if (ebreak) begin
            state_d = StHalt;
          end else if (next_pc[1:0] != 2'b00) begin
            state_d = StErr;
          end else begin
            pc_d    = next_pc;
            state_d = StReq;
          end
        end
      end
      StHalt, StErr: begin
        state_d = state_q;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  assign mem_req_addr = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign halted       = (state_q == StHalt);
  assign fetch_err    = (state_q == StErr);

endmodule

// File: tb/tb_gpc_fetch_ctrl.sv
module tb_gpc_fetch_ctrl;

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] D = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] next_pc = '0;
  logic        ebreak = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic        fetch_err;

  gpc_fetch_ctrl #(
    .RESET_PC(B),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .next_pc      (next_pc),
    .ebreak       (ebreak),
    .pc           (pc),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];
  bit  auto_mem = 1'b0;

  typedef struct {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic        ebreak;
    logic        exp_req_valid;
    logic        exp_inst_valid;
    logic        exp_halted;
    logic        exp_err;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs[10];

  function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic ir, logic [31:0] np,
                              logic eb, logic erv, logic eiv, logic eh, logic ee,
                              logic [31:0] epc, logic [31:0] einst);
    vec_t v;
    v.req_ready = rr;  v.rsp_valid = rv; v.rsp_data = rd; v.inst_ready = ir;
    v.next_pc = np;    v.ebreak = eb;    v.exp_req_valid = erv; v.exp_inst_valid = eiv;
    v.exp_halted = eh; v.exp_err = ee;   v.exp_pc = epc; v.exp_inst = einst;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock. In auto mode a simple memory answers every accepted request
  // one cycle later and the scoreboard checks each committed instruction.
  task automatic tick();
    bit          acc;
    logic [31:0] a;
    sb_t         e;
    acc = auto_mem && mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    if (auto_mem && inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_inst", inst, e.data);
        chk("sb_pc", pc, e.addr);
      end
    end
    if (acc) begin
      e.addr = a;
      e.data = mem_word(a);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rsp_valid = acc;
      mem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    auto_mem = 1'b0;
    sb_q.delete();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    inst_ready = 1'b0; next_pc = '0; ebreak = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From REQ: accept, respond with d, leave the DUT in HOLD.
  task automatic manual_fetch(input logic [31:0] d);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model_pc;
    logic [31:0] held;
    int          stall;

    // Basic cadence with a one-cycle memory and an always-ready core, ending in ebreak.
    vecs[0] = mk(1, 0, 0, 1, B + 4,  0, 1, 0, 0, 0, B,     0);
    vecs[1] = mk(1, 1, D, 1, B + 4,  0, 0, 0, 0, 0, B,     0);
    vecs[2] = mk(1, 0, 0, 1, B + 4,  0, 0, 1, 0, 0, B,     D);
    vecs[3] = mk(1, 0, 0, 1, B + 8,  0, 1, 0, 0, 0, B + 4, 0);
    vecs[4] = mk(1, 1, D, 1, B + 8,  0, 0, 0, 0, 0, B + 4, 0);
    vecs[5] = mk(1, 0, 0, 1, B + 8,  0, 0, 1, 0, 0, B + 4, D);
    vecs[6] = mk(1, 0, 0, 1, B + 12, 0, 1, 0, 0, 0, B + 8, 0);
    vecs[7] = mk(1, 1, D, 1, B + 12, 0, 0, 0, 0, 0, B + 8, 0);
    vecs[8] = mk(1, 0, 0, 1, B + 12, 1, 0, 1, 0, 0, B + 8, D);
    vecs[9] = mk(1, 0, 0, 1, B + 12, 0, 0, 0, 1, 0, B + 8, 0);

    do_reset();
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, B);
    for (int i = 0; i < 10; i++) begin
      mem_req_ready = vecs[i].req_ready;
      mem_rsp_valid = vecs[i].rsp_valid;
      mem_rsp_data  = vecs[i].rsp_data;
      inst_ready    = vecs[i].inst_ready;
      next_pc       = vecs[i].next_pc;
      ebreak        = vecs[i].ebreak;
      chk($sformatf("v%0d_req_valid", i), mem_req_valid, vecs[i].exp_req_valid);
      chk($sformatf("v%0d_inst_valid", i), inst_valid, vecs[i].exp_inst_valid);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].exp_halted);
      chk($sformatf("v%0d_err", i), fetch_err, vecs[i].exp_err);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_addr", i), mem_req_addr, vecs[i].exp_pc);
      if (vecs[i].exp_inst_valid) chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      tick();
    end
    ebreak = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("halt_no_req", mem_req_valid, 1'b0);
      tick();
    end
    chk("halt_sticky", halted, 1'b1);
    chk("halt_pc", pc, B + 8);

    // Request held while memory is not ready.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", mem_req_valid, 1'b1);
      chk("stall_req_addr", mem_req_addr, B);
      tick();
    end
    chk("stall_still_req", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_entered", mem_req_valid, 1'b0);

    // Scoreboarded run with random memory readiness and core stalls.
    do_reset();
    auto_mem = 1'b1;
    model_pc = B;
    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w < 40 && !inst_valid; w++) begin
        mem_req_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("hold_reached", inst_valid, 1'b1);
      if (!inst_valid) break;
      chk("hold_pc", pc, model_pc);
      stall = (n == 0) ? 4 : int'($urandom_range(0, 3));
      held  = inst;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("core_stall_valid", inst_valid, 1'b1);
        chk("core_stall_inst", inst, held);
        chk("core_stall_noreq", mem_req_valid, 1'b0);
        chk("core_stall_pc", pc, model_pc);
      end
      inst_ready = 1'b1;
      next_pc    = model_pc + 4;
      tick();
      inst_ready = 1'b0;
      chk("post_commit_valid", inst_valid, 1'b0);
      model_pc = model_pc + 4;
    end
    auto_mem = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Timeout: fetch_err exactly 16 cycles after entering WAIT.
    do_reset();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("to_in_wait", fetch_err, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to_err_c%0d", i), fetch_err, (i == 16));
    end
    chk("to_pc", pc, B);
    chk("to_no_req", mem_req_valid, 1'b0);

    // Response in the last timeout cycle wins, then a misaligned next_pc faults.
    do_reset();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5677;
    tick();
    mem_rsp_valid = 1'b0;
    chk("race_rsp_wins", inst_valid, 1'b1);
    chk("race_no_err", fetch_err, 1'b0);
    chk("race_inst", inst, 32'h1234_5677);
    inst_ready = 1'b1;
    next_pc    = B + 6;
    tick();
    inst_ready = 1'b0;
    chk("misalign_err", fetch_err, 1'b1);
    chk("misalign_pc", pc, B);
    chk("misalign_not_halted", halted, 1'b0);
    chk("misalign_inst_valid", inst_valid, 1'b0);

    // ebreak outranks a misaligned next_pc.
    do_reset();
    manual_fetch(D);
    inst_ready = 1'b1;
    next_pc    = B + 2;
    ebreak     = 1'b1;
    tick();
    inst_ready = 1'b0;
    ebreak     = 1'b0;
    chk("prio_halted", halted, 1'b1);
    chk("prio_no_err", fetch_err, 1'b0);

    // Reset mid-WAIT, then a stale response is ignored.
    do_reset();
    manual_fetch(D);
    inst_ready = 1'b1;
    next_pc    = B + 32'h10;
    tick();
    inst_ready = 1'b0;
    chk("rw_pc_adv", pc, B + 32'h10);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", mem_req_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_pc_reset", pc, B);
    chk("rw_inst_reset", inst, 32'h0);
    chk("rw_req", mem_req_valid, 1'b1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hdead_beef;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stale_ignored_valid", inst_valid, 1'b0);
    chk("stale_ignored_req", mem_req_valid, 1'b1);
    manual_fetch(32'h0020_0113);
    chk("fresh_valid", inst_valid, 1'b1);
    chk("fresh_inst", inst, 32'h0020_0113);
    chk("fresh_pc", pc, B);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
